cond_ex_stage: RTL and testbench

//  Execute-stage back end placed directly downstream of the ALU: holds the architectural NZCV flag register.

---
 rtl/cond_ex_stage.sv | 127 ++++++++++++
 tb/tb_cond_ex_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_ex_stage.sv
// cond_ex_stage: execute-stage back end sitting directly after the ALU.
// It holds the NZCV flag register and checks each instruction's ARM
// condition field against those flags. Register, memory and PC write
// enables are gated by the result of that check. The flags are updated only
// by instructions that pass. The result is registered into the EX/MEM
// register behind a valid/ready handshake, and there is no skid buffer.
// Optional feature: define COND_SQUASH_CNT_EN to add the squash_cnt output,
// which counts condition-failed instructions.
module cond_ex_stage #(
    parameter int          DATA_W    = 32,
    parameter int          REG_AW    = 4,
    parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] Result,
    input  logic [3:0]        ALUFlags,
    input  logic [3:0]        Cond,
    input  logic [1:0]        FlagWrite,
    input  logic              RegWrite,
    input  logic              MemWrite,
    input  logic              PCSrc,
    input  logic              MemtoReg,
    input  logic [REG_AW-1:0] WA3,
    input  logic [DATA_W-1:0] WriteData,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ResultM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [REG_AW-1:0] WA3M,
    output logic              MemtoRegM,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              PCSrcM,
`ifdef COND_SQUASH_CNT_EN
    output logic [15:0]       squash_cnt,
`endif
    output logic [3:0]        Flags
);

    logic cond_ex;
    logic accept;
    logic n, z, c, v;

    assign {n, z, c, v} = Flags;
    assign in_ready     = ~out_valid | out_ready;
    // flush kills the incoming instruction as well as the stage contents
    assign accept       = in_valid & in_ready & ~flush;

    // Decode the condition from the committed flags, not from the ALU flags
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Flag register: only passing, accepted instructions commit their flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Flags <= FLAGS_RST;
        end else if (accept && cond_ex) begin
            if (FlagWrite[1]) Flags[3:2] <= ALUFlags[3:2];
            if (FlagWrite[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end

    // EX/MEM register: load on accept, drain on out_ready, hold on stall.
    // A failed instruction still loads, as a bubble with its enables cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            ResultM    <= '0;
            WriteDataM <= '0;
            WA3M       <= '0;
            MemtoRegM  <= 1'b0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            PCSrcM     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
            PCSrcM    <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            ResultM    <= Result;
            WriteDataM <= WriteData;
            WA3M       <= WA3;
            MemtoRegM  <= MemtoReg;
            RegWriteM  <= RegWrite & cond_ex;
            MemWriteM  <= MemWrite & cond_ex;
            PCSrcM     <= PCSrc & cond_ex;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef COND_SQUASH_CNT_EN
    // Count squashed instructions that wanted to write something; wraps
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            squash_cnt <= 16'h0000;
        else if (accept && !cond_ex && (RegWrite || MemWrite || PCSrc))
            squash_cnt <= squash_cnt + 16'h0001;
    end
`endif

endmodule

// File: tb/tb_cond_ex_stage.sv
// Self-checking bench for cond_ex_stage.
// Expected EX/MEM entries are queued when an instruction is accepted.
// They are popped at each downstream handshake and compared there.
// A table sweeps every condition code against every NZCV value.
module tb_cond_ex_stage;

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] Result, WriteData, ResultM, WriteDataM;
    logic [3:0]  ALUFlags, Cond, WA3, WA3M, Flags;
    logic [1:0]  FlagWrite;
    logic        RegWrite, MemWrite, PCSrc, MemtoReg;
    logic        MemtoRegM, RegWriteM, MemWriteM, PCSrcM;
`ifdef COND_SQUASH_CNT_EN
    logic [15:0] squash_cnt;
`endif

    cond_ex_stage #(.DATA_W(32), .REG_AW(4), .FLAGS_RST(4'b0000)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .Result(Result), .ALUFlags(ALUFlags), .Cond(Cond), .FlagWrite(FlagWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .PCSrc(PCSrc), .MemtoReg(MemtoReg),
        .WA3(WA3), .WriteData(WriteData),
        .out_valid(out_valid), .out_ready(out_ready),
        .ResultM(ResultM), .WriteDataM(WriteDataM), .WA3M(WA3M), .MemtoRegM(MemtoRegM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .PCSrcM(PCSrcM),
`ifdef COND_SQUASH_CNT_EN
        .squash_cnt(squash_cnt),
`endif
        .Flags(Flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] wd;
        logic [3:0]  wa;
        logic        mtr, rw, mw, pc;
    } exp_t;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] nzcv;
        logic       pass;
    } vec_t;

    exp_t        q[$];
    vec_t        tbl[256];
    int          errs = 0;
    int          checks = 0;
    logic        m_ov;
    logic [3:0]  m_flags;
    logic [15:0] m_sq;

    // Reference decode: cond[3:1] picks a base test, cond[0] inverts it
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic fn, fz, fc, fv, b;
        {fn, fz, fc, fv} = f;
        case (c[3:1])
            3'd0: b = fz;
            3'd1: b = fc;
            3'd2: b = fn;
            3'd3: b = fv;
            3'd4: b = fc & ~fz;
            3'd5: b = (fn == fv);
            3'd6: b = ~fz & (fn == fv);
            default: b = 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic setin(input logic v, input logic [3:0] c, input logic [1:0] fw,
                         input logic rw, input logic mw, input logic pc,
                         input logic [31:0] res, input logic [3:0] af);
        in_valid  = v;  Cond = c;  FlagWrite = fw;
        RegWrite  = rw; MemWrite = mw; PCSrc = pc;
        Result    = res; ALUFlags = af;
        WA3       = 4'($urandom_range(0, 15));
        WriteData = $urandom;
        MemtoReg  = 1'($urandom_range(0, 1));
    endtask

    // One clock: check in_ready, advance the model, then check state after the edge
    task automatic cyc();
        logic acc, ce;
        exp_t e;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, ~m_ov | out_ready});
        acc = in_valid & (~m_ov | out_ready) & ~flush;
        ce  = ref_cond(Cond, m_flags);
        e.res = Result; e.wd = WriteData; e.wa = WA3; e.mtr = MemtoReg;
        e.rw = RegWrite & ce; e.mw = MemWrite & ce; e.pc = PCSrc & ce;
        @(posedge clk);
        #1;
        if (flush) begin
            m_ov = 1'b0;
            q.delete();
        end else if (acc) begin
            q.push_back(e);
            m_ov = 1'b1;
            if (ce && FlagWrite[1]) m_flags[3:2] = ALUFlags[3:2];
            if (ce && FlagWrite[0]) m_flags[1:0] = ALUFlags[1:0];
            if (!ce && (RegWrite || MemWrite || PCSrc)) m_sq = m_sq + 16'd1;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        chk("Flags", {28'd0, Flags}, {28'd0, m_flags});
`ifdef COND_SQUASH_CNT_EN
        chk("squash_cnt", {16'd0, squash_cnt}, {16'd0, m_sq});
`endif
    endtask

    task automatic model_reset();
        m_ov = 1'b0; m_flags = 4'b0000; m_sq = 16'd0;
        q.delete();
    endtask

    // Scoreboard: every downstream handshake consumes the oldest expected entry
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready && !flush) begin
            if (q.size() == 0) begin
                checks++; errs++;
                $display("FAIL sb_empty: out_valid handshake with no entry expected at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_ResultM", ResultM, e.res);
                chk("sb_WriteDataM", WriteDataM, e.wd);
                chk("sb_ctrl", {24'd0, WA3M, MemtoRegM, RegWriteM, MemWriteM, PCSrcM},
                    {24'd0, e.wa, e.mtr, e.rw, e.mw, e.pc});
            end
        end
    end

    initial begin
        logic [31:0] hold_res;
        logic [2:0]  hold_en;

        for (int i = 0; i < 256; i++) begin
            tbl[i].cond = 4'(i >> 4);
            tbl[i].nzcv = 4'(i);
            tbl[i].pass = ref_cond(4'(i >> 4), 4'(i));
        end

        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        setin(1'b0, 4'he, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        model_reset();
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_Flags", {28'd0, Flags}, 32'd0);
        chk("rst_ResultM", ResultM, 32'd0);
        chk("rst_enables", {29'd0, RegWriteM, MemWriteM, PCSrcM}, 32'd0);
`ifdef COND_SQUASH_CNT_EN
        chk("rst_squash", {16'd0, squash_cnt}, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // AL register write goes straight through
        setin(1'b1, 4'he, 2'b00, 1'b1, 1'b0, 1'b0, 32'h1234, 4'h0);
        cyc();
        chk("al_ResultM", ResultM, 32'h1234);
        chk("al_RegWriteM", {31'd0, RegWriteM}, 32'd1);

        // Flag-setting AL sets Z, the dependent EQ passes, and the NE becomes a bubble
        setin(1'b1, 4'he, 2'b11, 1'b0, 1'b0, 1'b0, 32'h1, 4'b0100);
        cyc();
        setin(1'b1, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h2, 4'h0);
        cyc();
        chk("dep_Flags", {28'd0, Flags}, 32'h4);
        chk("dep_MemWriteM", {31'd0, MemWriteM}, 32'd1);
        setin(1'b1, 4'h1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h3, 4'h0);
        cyc();
        chk("ne_MemWriteM", {31'd0, MemWriteM}, 32'd0);
        chk("ne_out_valid", {31'd0, out_valid}, 32'd1);

        // Clear Z, then a failing EQ must not touch the flags
        setin(1'b1, 4'he, 2'b11, 1'b0, 1'b0, 1'b0, 32'h4, 4'b1010);
        cyc();
        setin(1'b1, 4'h0, 2'b11, 1'b1, 1'b0, 1'b0, 32'h5, 4'b0101);
        cyc();
        chk("sq_Flags", {28'd0, Flags}, 32'ha);
        chk("sq_RegWriteM", {31'd0, RegWriteM}, 32'd0);

        // Backpressure: the first instruction loads, then the stage stalls for three cycles
        setin(1'b1, 4'he, 2'b00, 1'b1, 1'b0, 1'b1, 32'hbeef, 4'h0);
        cyc();
        out_ready = 1'b0;
        setin(1'b1, 4'he, 2'b11, 1'b1, 1'b1, 1'b0, 32'hcafe, 4'b1111);
        cyc();
        hold_res = ResultM;
        hold_en  = {RegWriteM, MemWriteM, PCSrcM};
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_ResultM", ResultM, hold_res);
            chk("stall_en", {29'd0, RegWriteM, MemWriteM, PCSrcM}, {29'd0, hold_en});
        end
        out_ready = 1'b1;
        cyc();
        chk("release_ResultM", ResultM, 32'hcafe);
        chk("release_Flags", {28'd0, Flags}, 32'hf);

        // flush with a flag-writing AL: nothing is committed and the stage empties
        flush = 1'b1;
        setin(1'b1, 4'he, 2'b11, 1'b1, 1'b1, 1'b1, 32'hdead, 4'b0000);
        cyc();
        flush = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_en", {29'd0, RegWriteM, MemWriteM, PCSrcM}, 32'd0);
        chk("flush_Flags", {28'd0, Flags}, 32'hf);

        // Condition-code sweep over all NZCV values
        for (int i = 0; i < 256; i++) begin
            setin(1'b1, 4'he, 2'b11, 1'b0, 1'b0, 1'b0, 32'(i), tbl[i].nzcv);
            cyc();
            setin(1'b1, tbl[i].cond, 2'b00, 1'b0, 1'b0, 1'b1, 32'(i), 4'h0);
            cyc();
            chk($sformatf("sweep_c%h_f%h", tbl[i].cond, tbl[i].nzcv),
                {31'd0, PCSrcM}, {31'd0, tbl[i].pass});
        end

        // Asynchronous reset between edges while holding a valid entry with flags set
        setin(1'b1, 4'he, 2'b11, 1'b1, 1'b0, 1'b0, 32'h77, 4'b1101);
        cyc();
        setin(1'b0, 4'he, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        out_ready = 1'b0;
        #2;
        chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_Flags", {28'd0, Flags}, 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Drain and confirm every queued entry was seen
        setin(1'b1, 4'he, 2'b00, 1'b1, 1'b0, 1'b0, 32'h99, 4'h0);
        cyc();
        setin(1'b0, 4'he, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) cyc();
        chk("drain_queue", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
